// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and state type for the PWM capture block
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        MEASURE = 2'd2
    } pwm_state_e;

    localparam int PWM_CNT_W      = 16;
    localparam int PWM_TIMEOUT    = 1024;
    // Period of the companion PWM output generator, in clk cycles.
    localparam int PWM_GEN_PERIOD = 255;

endpackage

// File: rtl/pwm_edge_detect.sv
// rtl/pwm_edge_detect.sv - two-flop synchroniser plus previous-value flop with edge strobes
module pwm_edge_detect (
    input  logic clk,
    input  logic rstn,
    input  logic pwm_in,
    output logic s2_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= pwm_in;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    // Both edges come from the same s2/prev pair, so rise and fall share one latency.
    assign s2_o   = s2_q;
    assign rise_o = s2_q & ~prev_q;
    assign fall_o = ~s2_q & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM input decoder measuring high time and period rise-to-rise
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W   = PWM_CNT_W,
    parameter int TIMEOUT = PWM_TIMEOUT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             pwm_in,
    input  logic             enable,
    input  logic             ack,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             overrun,
    output logic             stuck
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    logic s2;
    logic rise;
    logic fall;

    pwm_edge_detect u_edge (
        .clk    (clk),
        .rstn   (rstn),
        .pwm_in (pwm_in),
        .s2_o   (s2),
        .rise_o (rise),
        .fall_o (fall)
    );

    pwm_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;

    logic             pub;
    logic [CNT_W-1:0] pub_period;
    logic [CNT_W-1:0] pub_high;
    logic             pub_stuck;

    logic [CNT_W-1:0] high_time_q;
    logic [CNT_W-1:0] period_q;
    logic             valid_q;
    logic             overrun_q;
    logic             stuck_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_cnt_q <= hi_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_cnt_d   = hi_cnt_q;
        pub        = 1'b0;
        pub_period = '0;
        pub_high   = '0;
        pub_stuck  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: state_d = SYNC;
                SYNC, MEASURE: begin
                    if (state_q == MEASURE && fall) begin
                        hi_cnt_d = cnt_q;
                    end
                    // SYNC only arms on a rise so a partial first pulse is never published.
                    if (rise) begin
                        if (state_q == MEASURE) begin
                            pub        = 1'b1;
                            pub_period = cnt_q;
                            pub_high   = hi_cnt_q;
                        end
                        cnt_d   = ONE_C;
                        state_d = MEASURE;
                    end else if (cnt_q == TIMEOUT_C) begin
                        pub       = 1'b1;
                        pub_stuck = 1'b1;
                        pub_high  = s2 ? '1 : '0;
                        cnt_d     = '0;
                        state_d   = SYNC;
                    end else begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            high_time_q <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            stuck_q     <= 1'b0;
        end else if (pub) begin
            high_time_q <= pub_high;
            period_q    <= pub_period;
            stuck_q     <= pub_stuck;
            valid_q     <= 1'b1;
            // A concurrent ack consumes the old record, so the overwrite is not an overrun.
            if (ack) begin
                overrun_q <= 1'b0;
            end else if (valid_q) begin
                overrun_q <= 1'b1;
            end
        end else if (ack) begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end
    end

    assign high_time = high_time_q;
    assign period    = period_q;
    assign valid     = valid_q;
    assign overrun   = overrun_q;
    assign stuck     = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - randomized self-checking bench for pwm_capture against a timestamp model
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int TO = PWM_TIMEOUT;

    logic        clk = 1'b0;
    logic        rstn;
    logic        pwm_in;
    logic        enable;
    logic        ack;
    logic [15:0] high_time;
    logic [15:0] period;
    logic        valid;
    logic        overrun;
    logic        stuck;

    pwm_capture #(.CNT_W(PWM_CNT_W), .TIMEOUT(PWM_TIMEOUT)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .pwm_in    (pwm_in),
        .enable    (enable),
        .ack       (ack),
        .high_time (high_time),
        .period    (period),
        .valid     (valid),
        .overrun   (overrun),
        .stuck     (stuck)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: works on pin sample timestamps; records are derived from
    // the times of accepted rises, falls and timeout deadlines.
    localparam int M_OFF = 0, M_HUNT = 1, M_MEAS = 2;
    bit          hist [0:65535];
    int          cyc = 0;
    int          last_rst = -100;
    int          m_mode = M_OFF;
    int          t_anchor = 0;
    int          t_fall = 0;
    int          deadline = 0;
    logic        m_valid = 1'b0;
    logic        m_ovr = 1'b0;
    logic        m_stk = 1'b0;
    logic [15:0] m_per = '0;
    logic [15:0] m_hi = '0;

    function automatic bit pin_at(input int k);
        if (k < 0 || k <= last_rst) return 1'b0;
        return hist[k];
    endfunction

    always @(posedge clk) begin
        int  n;
        bit  d_now, d_prev, m_rise, m_fall, pub, p_stk;
        int  p_per, p_hi;
        n = cyc;
        hist[n] = pwm_in;
        if (!rstn) begin
            last_rst = n;
            m_mode = M_OFF;
            m_valid = 0; m_ovr = 0; m_stk = 0; m_per = '0; m_hi = '0;
        end else begin
            d_now  = pin_at(n - 2);
            d_prev = pin_at(n - 3);
            m_rise = d_now & ~d_prev;
            m_fall = ~d_now & d_prev;
            pub = 0; p_stk = 0; p_per = 0; p_hi = 0;
            if (!enable) begin
                m_mode = M_OFF;
            end else if (m_mode == M_OFF) begin
                m_mode = M_HUNT;
                deadline = n + 1 + TO;
            end else if (m_rise) begin
                if (m_mode == M_MEAS) begin
                    pub = 1; p_per = n - t_anchor; p_hi = t_fall - t_anchor;
                end
                t_anchor = n;
                m_mode = M_MEAS;
                deadline = n + TO;
            end else if (n == deadline) begin
                pub = 1; p_stk = 1; p_per = 0; p_hi = d_now ? 16'hFFFF : 0;
                m_mode = M_HUNT;
                deadline = n + 1 + TO;
            end else if (m_fall && m_mode == M_MEAS) begin
                t_fall = n;
            end
            if (pub) begin
                if (ack) m_ovr = 0;
                else if (m_valid) m_ovr = 1;
                m_valid = 1; m_stk = p_stk;
                m_per = 16'(p_per); m_hi = 16'(p_hi);
            end else if (ack) begin
                m_valid = 0; m_ovr = 0;
            end
        end
        cyc++;
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en)
            check_eq("rec", {29'd0, valid, overrun, stuck, period, high_time},
                     {29'd0, m_valid, m_ovr, m_stk, m_per, m_hi});
    end

    // Stimulus: generator model and ack policy (0 none, 1 auto, 2 held, 3 random).
    int level = 64;
    int phase = 0;
    int ack_mode = 0;

    task automatic step();
        @(posedge clk);
        #1;
        phase = (phase + 1) % PWM_GEN_PERIOD;
        pwm_in = (phase < level);
        case (ack_mode)
            1:       ack = valid && !ack;
            2:       ack = 1'b1;
            3:       ack = ($urandom_range(0, 3) == 0);
            default: ack = 1'b0;
        endcase
    endtask

    task automatic wait_rec(input string tag, input int budget, input bit want_stuck, output int waited);
        waited = 0;
        while (waited < budget) begin
            step();
            waited++;
            if (valid && stuck == want_stuck) break;
        end
        check_eq(tag, {63'd0, valid && (stuck == want_stuck)}, 64'd1);
    endtask

    task automatic step_to_phase(input int ph);
        for (int i = 0; i < 2 * PWM_GEN_PERIOD; i++) begin
            if (phase == ph) break;
            step();
        end
    endtask

    task automatic run_level(input string tag, input int lvl);
        int w;
        level = lvl;
        wait_rec({tag, "_settle0"}, 800, 0, w);
        wait_rec({tag, "_settle1"}, 800, 0, w);
        wait_rec({tag, "_rec"}, 800, 0, w);
        check_eq({tag, "_interval"}, 64'(w), 64'(PWM_GEN_PERIOD));
        check_eq({tag, "_period"}, 64'(period), 64'(PWM_GEN_PERIOD));
        check_eq({tag, "_high"}, 64'(high_time), 64'(lvl));
        check_eq({tag, "_flags"}, {62'd0, stuck, overrun}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        rstn = 1'b0; enable = 1'b0; ack = 1'b0; pwm_in = 1'b0;
        step();
        chk_en = 1;
        step(); step();
        check_eq("reset_rec", {29'd0, valid, overrun, stuck, period, high_time}, 64'd0);
        rstn = 1'b1;

        // Nominal level and the boundary widths.
        enable = 1'b1; ack_mode = 1;
        run_level("lvl64", 64);
        run_level("lvl1", 1);
        run_level("lvl254", 254);

        // Stuck low, then stuck high, each re-reporting every TIMEOUT+1 cycles.
        level = 0;
        wait_rec("stk0_first", 2 * TO + 600, 1, w);
        check_eq("stk0_high", 64'(high_time), 64'd0);
        check_eq("stk0_period", 64'(period), 64'd0);
        wait_rec("stk0_again", TO + 10, 1, w);
        check_eq("stk0_interval", 64'(w), 64'(TO + 1));
        level = 255;
        wait_rec("stk1_first", 2 * TO + 600, 1, w);
        wait_rec("stk1_again", TO + 10, 1, w);
        check_eq("stk1_interval", 64'(w), 64'(TO + 1));
        check_eq("stk1_high", 64'(high_time), 64'hFFFF);
        check_eq("stk1_period", 64'(period), 64'd0);

        // Overrun without ack, clear by ack, then ack coinciding with publishes.
        run_level("lvl100", 100);
        ack_mode = 0;
        repeat (3 * PWM_GEN_PERIOD) step();
        check_eq("ovr_set", {62'd0, valid, overrun}, 64'd3);
        check_eq("ovr_latest", 64'(high_time), 64'd100);
        step_to_phase(110);
        ack = 1'b1;
        step();
        check_eq("ovr_clear", {62'd0, valid, overrun}, 64'd0);
        ack_mode = 2;
        repeat (3 * PWM_GEN_PERIOD) step();
        ack_mode = 1;

        // Enable dropped holds outputs; raised mid-high discards the partial pulse.
        enable = 1'b0;
        repeat (400) step();
        level = 200;
        step_to_phase(50);
        enable = 1'b1;
        wait_rec("en_first", 900, 0, w);
        check_eq("en_latency", {63'd0, w >= 400}, 64'd1);
        check_eq("en_period", 64'(period), 64'(PWM_GEN_PERIOD));
        check_eq("en_high", 64'(high_time), 64'd200);

        // Reset mid-period.
        run_level("lvl80", 80);
        step_to_phase(150);
        rstn = 1'b0;
        step();
        check_eq("rst_mid", {29'd0, valid, overrun, stuck, period, high_time}, 64'd0);
        rstn = 1'b1;
        wait_rec("rst_first", 900, 0, w);
        check_eq("rst_period", 64'(period), 64'(PWM_GEN_PERIOD));
        check_eq("rst_high", 64'(high_time), 64'd80);

        // Randomized levels, ack timing, enable drops and resets against the model.
        for (int r = 0; r < 10; r++) begin
            int ncyc;
            if ($urandom_range(0, 9) == 0) level = ($urandom_range(0, 1) == 0) ? 0 : 255;
            else level = $urandom_range(1, 254);
            ack_mode = ($urandom_range(0, 1) == 0) ? 1 : 3;
            ncyc = $urandom_range(600, 1500);
            for (int i = 0; i < ncyc; i++) begin
                step();
                if (!enable) enable = ($urandom_range(0, 19) == 0);
                else if ($urandom_range(0, 399) == 0) enable = 1'b0;
                rstn = ($urandom_range(0, 1999) != 0);
            end
            enable = 1'b1;
            rstn = 1'b1;
        end
        step(); step();
        chk_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
PWM input decoder: the receive-side counterpart of the team's PWM output generator. It synchronises an asynchronous PWM input and measures high time and period in clk cycles, rise-to-rise. Each completed period is published as a measurement record with a valid/ack handshake to the CPU peripheral bus. A constant input (duty 0% or 100%) is detected by a timeout and reported as stuck low or stuck high.

Parameters:
CNT_W, 16, width of the cycle counters and of the high_time/period outputs.
TIMEOUT, 1024, cycles without a rising edge before a stuck report. Must satisfy 2 <= TIMEOUT < 2^CNT_W.

Ports:
clk  input  1  system clock
rstn  input  1  reset, synchronous, active-low
pwm_in  input  1  asynchronous PWM input pin
enable  input  1  capture enable
ack  input  1  one-cycle pulse: consumer has read the record; clears valid and overrun
high_time  output  CNT_W  cycles high in the last period; on stuck: all-ones if high, 0 if low
period  output  CNT_W  cycles rise-to-rise of the last period; 0 on stuck report
valid  output  1  a record is waiting
overrun  output  1  sticky: a record was overwritten while valid=1
stuck  output  1  last record was a timeout report

Behaviour:
- Reset (rstn=0 at posedge): every output is 0, sync flops are 0, counter is 0, state is IDLE.
- Synchroniser: two flops, then a third flop holding the previous value.
  - rise = s2 & ~prev; fall = ~s2 & prev.
  - Rise and fall have identical latency (3 cycles from pin to detection), so measured widths are exact.
- State machine (states: IDLE, SYNC, MEASURE):
  - Any state, enable=0: go to IDLE, cnt <= 0. Outputs and valid hold their values.
  - IDLE, enable=1: go to SYNC.
  - SYNC: wait for the first rise and discard any partial pulse. Fall is ignored. On rise: cnt <= 1, go to MEASURE.
  - MEASURE:
    - On fall: hi_cnt <= cnt.
    - On rise: publish period=cnt and high_time=hi_cnt, then cnt <= 1.
  - Otherwise, in SYNC and MEASURE: cnt <= cnt+1.
- Worked timing: rise detected at cycle 0 and fall at cycle H gives high_time=H. The next rise at cycle P gives period=P.
- Timeout: if cnt == TIMEOUT in SYNC or MEASURE with no rise in that cycle:
  - publish a stuck record: stuck=1, period=0, high_time = s2 ? all-ones : 0;
  - cnt <= 0; go to SYNC.
  - A steady input therefore re-reports every TIMEOUT+1 cycles.
- Publish (normal or stuck):
  - All record fields update on the same edge; valid <= 1.
  - stuck <= 0 for a normal record.
  - If valid was already 1 and ack is not asserted this cycle: overrun <= 1.
- ack without a concurrent publish: valid <= 0, overrun <= 0.
- ack with a concurrent publish: valid stays 1 and overrun <= 0. The new record is kept, and ack does not set overrun.
- Record fields are stable whenever no publish is occurring.
- Generator compatibility: the generator has a 255-cycle period.
  - Level L in 1..254 gives period=255, high_time=L.
  - Level 0 gives a stuck-low report; level 255 gives a stuck-high report.
- Reset mid-measurement: the partial period is lost. After reset with enable=1, the path is IDLE, then SYNC, then a fresh measurement.

Decomposition:
- Shared package pwm_pkg:
  - state enum {IDLE, SYNC, MEASURE};
  - default CNT_W and TIMEOUT constants;
  - PWM_GEN_PERIOD=255 constant, shared with the generator and the bench.
- One sub-module: pwm_edge_detect. It contains the 2-flop synchroniser and prev flop, and outputs s2, rise and fall. All flops are reset to 0 by rstn.

Test Plan:
1. Generator level 64, enable=1, ack after each valid -> first valid after one full period; period=255, high_time=64, stuck=0, overrun=0. Repeats every 255 cycles.
2. Levels 1 and 254 -> high_time=1 / 254, period=255 (boundary widths exact, no off-by-one).
3. Level 0, then level 255 -> stuck=1, period=0 within TIMEOUT+1 cycles of the last edge; high_time=0 for level 0, 16'hFFFF for level 255. The report re-arms every 1025 cycles.
4. Level 100 with no ack for 3 periods -> overrun=1 and the record is the latest one. Ack -> valid=0, overrun=0. Ack on the exact publish cycle -> valid stays 1, overrun=0.
5. enable raised while the input is mid-high -> no record for the partial pulse; first record after the next rise-to-rise is correct. enable dropped -> outputs hold, no new records.
6. rstn low for 1 cycle mid-period -> all outputs 0 the next cycle; the first record after release is a full correct period.
